stack_access_unit: RTL and testbench
====================================

STACK_ACCESS_UNIT -- requirements
Module: stack_access_unit

Interface
REQ-001 The block SHALL have parameter REG_BITS, default 32, which sets the data word width.
REQ-002 The block SHALL have parameter DEPTH, default 16 (a power of two), which sets the number of stack words.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 The block SHALL have port StackUpdateMode, input, 2 bits, with encoding 10 = push two, 11 = push one, 00 = hold, 01 = pop one.
REQ-006 The block SHALL have ports op_valid (input, 1 bit) and op_ready (output, 1 bit); an op is accepted on a cycle where both are 1.
REQ-007 The block SHALL have ports wr_data0 and wr_data1, input, REG_BITS each: the first and second push words.
REQ-008 The block SHALL have ports rd_valid (output, 1 bit) and rd_data (output, REG_BITS): the pop result.
REQ-009 The block SHALL have port SP_out, output, clog2(DEPTH)+1 bits: the current stack pointer.
REQ-010 The block SHALL have ports full and empty, output, 1 bit each: SP_out == 0 and SP_out == DEPTH respectively.
REQ-011 The block SHALL have ports overflow_err and underflow_err, output, 1 bit each: sticky error flags.

Function
REQ-012 The stack SHALL grow downward; SP_out points at the top word; SP_out ranges over 0..DEPTH, and SP_out == DEPTH means empty.
REQ-013 On push one, the block SHALL write mem[SP-1] <= wr_data0 and set SP <= SP-1, completing in one cycle.
REQ-014 On push two, the block SHALL use state IDLE -> PUSH2 with a single write port:
- Accept cycle: mem[SP-1] <= wr_data0, SP <= SP-1.
- PUSH2 cycle: mem[SP-1] <= latched wr_data1, SP <= SP-1, return to IDLE.
REQ-015 op_ready SHALL be 0 while in PUSH2 and 1 in IDLE.
REQ-016 On pop, the block SHALL set rd_data <= mem[SP] and SP <= SP+1; rd_valid SHALL be 1 for exactly the one cycle after acceptance.
REQ-017 rd_data SHALL hold its last value while rd_valid is 0.
REQ-018 Hold (00), or op_valid == 0, SHALL leave SP, memory, rd_data and state unchanged, and rd_valid SHALL be 0.
REQ-019 Push one with SP == 0, or push two with SP < 2, SHALL be rejected:
- SP and memory unchanged.
- No PUSH2 entry.
- overflow_err set.
- op_ready stays 1.
REQ-020 Pop with SP == DEPTH SHALL be rejected: SP unchanged, rd_valid stays 0, underflow_err set.
REQ-021 Back-to-back accepted ops SHALL be supported at one op per cycle, except during PUSH2.
REQ-022 A pop accepted the cycle after a push one SHALL return the word just pushed.
REQ-023 All SP arithmetic SHALL be unsigned in clog2(DEPTH)+1 bits with no wrap-around; the overflow/underflow rejection rules are the only boundary handling.

Reset
REQ-024 While rst_n == 0 at a clock edge, the block SHALL set:
- SP_out = DEPTH, state = IDLE, op_ready = 1.
- rd_valid = 0, rd_data = 0.
- overflow_err = 0, underflow_err = 0.
- empty = 1, full = 0.
REQ-025 Reset during PUSH2 SHALL abort the second write and leave SP_out = DEPTH.
REQ-026 Memory contents SHALL NOT be reset.
REQ-027 Error flags SHALL clear only by reset.

Configuration
REQ-028 The block SHALL support macro STACK_ACCESS_ERR_FLAGS_EN.
- Defined: overflow_err and underflow_err behave per REQ-019/020/027.
- Undefined: both ports are present but tied 0, and illegal ops are still silently rejected.

Structure
REQ-029 A shared package SHALL hold the StackUpdateMode encodings (MODE_PUSH2, MODE_PUSH1, MODE_HOLD, MODE_POP) and the FSM state typedef (IDLE, PUSH2).
REQ-030 The storage SHALL be one sub-module, stack_ram (single write port, synchronous read, REG_BITS x DEPTH).
REQ-031 Control, SP and the FSM SHALL remain in stack_access_unit.

Verification
REQ-032 Reset, then push one 0xA5 with SP 16: SP_out = 15 next cycle; then pop: rd_valid = 1 and rd_data = 0xA5 one cycle later, SP_out = 16, empty = 1.
REQ-033 Push two (0x11, 0x22) from SP 16: op_ready = 0 for one cycle, SP_out = 14; pop twice: rd_data 0x22 then 0x11.
REQ-034 Pop with SP 16: underflow_err = 1, SP_out = 16, rd_valid = 0; a following legal push still succeeds.
REQ-035 Fill to SP 1, then push two: rejected, overflow_err = 1, SP_out = 1; push one then succeeds, SP_out = 0, full = 1.
REQ-036 rst_n = 0 during the PUSH2 cycle: next cycle SP_out = 16, op_ready = 1, flags = 0.
REQ-037 With STACK_ACCESS_ERR_FLAGS_EN undefined, rerun REQ-034/035: flags stay 0 and SP behaviour is identical.

Source files
------------

// File: rtl/stack_access_unit_pkg.sv
// Shared definitions for the stack access unit: StackUpdateMode encodings
// and the two-state push FSM.
package stack_access_unit_pkg;

    // StackUpdateMode encodings
    localparam logic [1:0] MODE_PUSH2 = 2'b10;
    localparam logic [1:0] MODE_PUSH1 = 2'b11;
    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_POP   = 2'b01;

    // FSM state type; PUSH2 is the cycle that writes the latched second word
    typedef logic [0:0] state_t;
    localparam state_t IDLE  = 1'b0;
    localparam state_t PUSH2 = 1'b1;

endpackage

// File: rtl/stack_ram.sv
// Stack storage: REG_BITS x DEPTH, one write port, one registered read port.
// Array contents are never reset; only the read output register is.
module stack_ram #(
    parameter int unsigned REG_BITS = 32,
    parameter int unsigned DEPTH    = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_we,
    input  logic [$clog2(DEPTH)-1:0]   i_waddr,
    input  logic [REG_BITS-1:0]        i_wdata,
    input  logic                       i_re,
    input  logic [$clog2(DEPTH)-1:0]   i_raddr,
    output logic [REG_BITS-1:0]        o_rd_data
);

    logic [REG_BITS-1:0] r_mem [DEPTH];
    logic [REG_BITS-1:0] r_rd_data;

    // Single write port
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Synchronous read; output holds between reads
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rd_data <= '0;
        end else if (i_re) begin
            r_rd_data <= r_mem[i_raddr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/stack_access_unit.sv
// Downward-growing stack controller: push one, push two (two-cycle, single
// write port), pop and hold. SP_out == DEPTH means empty, 0 means full.
// Optional macro STACK_ACCESS_ERR_FLAGS_EN enables the sticky overflow/underflow
// flags; without it both flags are tied 0 and illegal ops are silently dropped.
module stack_access_unit
    import stack_access_unit_pkg::*;
#(
    parameter int unsigned REG_BITS = 32,
    parameter int unsigned DEPTH    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               StackUpdateMode,
    input  logic                     op_valid,
    output logic                     op_ready,
    input  logic [REG_BITS-1:0]      wr_data0,
    input  logic [REG_BITS-1:0]      wr_data1,
    output logic                     rd_valid,
    output logic [REG_BITS-1:0]      rd_data,
    output logic [$clog2(DEPTH):0]   SP_out,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow_err,
    output logic                     underflow_err
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned SPW = AW + 1;
    localparam logic [SPW-1:0] SP_EMPTY = SPW'(DEPTH);
    localparam logic [SPW-1:0] SP_ONE   = SPW'(1);
    localparam logic [SPW-1:0] SP_TWO   = SPW'(2);

    state_t                r_state;
    logic [SPW-1:0]        r_sp;
    logic                  r_rd_valid;
    logic [REG_BITS-1:0]   r_wr_data1;

    logic                  w_accept;
    logic                  w_push1;
    logic                  w_push2;
    logic                  w_pop;
    logic                  w_push1_ok;
    logic                  w_push2_ok;
    logic                  w_pop_ok;
    logic [SPW-1:0]        w_sp_dec;
    logic                  w_we;
    logic [REG_BITS-1:0]   w_wdata;

    assign w_accept = op_valid && (r_state == IDLE);

    // Decode the accepted op
    always_comb begin
        w_push1 = 1'b0;
        w_push2 = 1'b0;
        w_pop   = 1'b0;
        case (StackUpdateMode)
            MODE_PUSH1: w_push1 = w_accept;
            MODE_PUSH2: w_push2 = w_accept;
            MODE_POP:   w_pop   = w_accept;
            MODE_HOLD:  ;
            default:    ;
        endcase
    end

    // Boundary rules are the only guard against SP wrap-around
    assign w_push1_ok = w_push1 && (r_sp >= SP_ONE);
    assign w_push2_ok = w_push2 && (r_sp >= SP_TWO);
    assign w_pop_ok   = w_pop && (r_sp != SP_EMPTY);
    assign w_sp_dec   = r_sp - SP_ONE;

    // Reset gates the write so a reset during PUSH2 aborts the second word
    assign w_we    = rst_n && (w_push1_ok || w_push2_ok || (r_state == PUSH2));
    assign w_wdata = (r_state == PUSH2) ? r_wr_data1 : wr_data0;

    stack_ram #(
        .REG_BITS (REG_BITS),
        .DEPTH    (DEPTH)
    ) u_stack_ram (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_we      (w_we),
        .i_waddr   (w_sp_dec[AW-1:0]),
        .i_wdata   (w_wdata),
        .i_re      (w_pop_ok),
        .i_raddr   (r_sp[AW-1:0]),
        .o_rd_data (rd_data)
    );

    // FSM, stack pointer and pop-valid strobe
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_sp       <= SP_EMPTY;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_pop_ok;
            case (r_state)
                IDLE: begin
                    if (w_push1_ok) begin
                        r_sp <= w_sp_dec;
                    end else if (w_push2_ok) begin
                        r_sp    <= w_sp_dec;
                        r_state <= PUSH2;
                    end else if (w_pop_ok) begin
                        r_sp <= r_sp + SP_ONE;
                    end
                end
                PUSH2: begin
                    r_sp    <= w_sp_dec;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Second push word is captured on acceptance, written in PUSH2
    always_ff @(posedge clk) begin
        if (w_push2_ok) begin
            r_wr_data1 <= wr_data1;
        end
    end

`ifdef STACK_ACCESS_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if ((w_push1 && !w_push1_ok) || (w_push2 && !w_push2_ok)) begin
                r_overflow <= 1'b1;
            end
            if (w_pop && !w_pop_ok) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign overflow_err  = r_overflow;
    assign underflow_err = r_underflow;
`else
    assign overflow_err  = 1'b0;
    assign underflow_err = 1'b0;
`endif

    assign op_ready = (r_state == IDLE);
    assign rd_valid = r_rd_valid;
    assign SP_out   = r_sp;
    assign full     = (r_sp == '0);
    assign empty    = (r_sp == SP_EMPTY);

endmodule

// File: tb/tb_stack_access_unit.sv
// Bench for stack_access_unit: directed scenarios with literal expectations,
// then randomized ops checked every cycle against a queue-based stack model.
module tb_stack_access_unit;

    localparam int unsigned W     = 32;
    localparam int unsigned D     = 16;
`ifdef STACK_ACCESS_ERR_FLAGS_EN
    localparam bit FLAGS_EN = 1'b1;
`else
    localparam bit FLAGS_EN = 1'b0;
`endif

    localparam logic [1:0] M_PUSH2 = 2'b10;
    localparam logic [1:0] M_PUSH1 = 2'b11;
    localparam logic [1:0] M_HOLD  = 2'b00;
    localparam logic [1:0] M_POP   = 2'b01;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    mode;
    logic          op_valid;
    logic          op_ready;
    logic [W-1:0]  wr_data0;
    logic [W-1:0]  wr_data1;
    logic          rd_valid;
    logic [W-1:0]  rd_data;
    logic [4:0]    sp_out;
    logic          full;
    logic          empty;
    logic          overflow_err;
    logic          underflow_err;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: stk[0] is the top of stack
    logic [W-1:0] stk[$];
    bit           m_pending;
    logic [W-1:0] m_pend_d1;
    bit           m_rd_valid;
    logic [W-1:0] m_rd_data;
    bit           m_ovf;
    bit           m_unf;

    stack_access_unit #(
        .REG_BITS (W),
        .DEPTH    (D)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .StackUpdateMode (mode),
        .op_valid        (op_valid),
        .op_ready        (op_ready),
        .wr_data0        (wr_data0),
        .wr_data1        (wr_data1),
        .rd_valid        (rd_valid),
        .rd_data         (rd_data),
        .SP_out          (sp_out),
        .full            (full),
        .empty           (empty),
        .overflow_err    (overflow_err),
        .underflow_err   (underflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Stack semantics applied once per clock edge
    task automatic model_step(input logic rst, input logic [1:0] md, input logic vld,
                              input logic [W-1:0] d0, input logic [W-1:0] d1);
        m_rd_valid = 1'b0;
        if (!rst) begin
            stk.delete();
            m_pending = 1'b0;
            m_rd_data = '0;
            m_ovf     = 1'b0;
            m_unf     = 1'b0;
        end else if (m_pending) begin
            stk.push_front(m_pend_d1);
            m_pending = 1'b0;
        end else if (vld) begin
            case (md)
                M_PUSH1: if (stk.size() < D) stk.push_front(d0); else m_ovf = 1'b1;
                M_PUSH2: begin
                    if (stk.size() + 2 <= D) begin
                        stk.push_front(d0);
                        m_pending = 1'b1;
                        m_pend_d1 = d1;
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
                M_POP: begin
                    if (stk.size() > 0) begin
                        m_rd_data  = stk.pop_front();
                        m_rd_valid = 1'b1;
                    end else begin
                        m_unf = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic compare_all();
        int sp;
        sp = D - stk.size();
        chk("sp_out",   W'(sp_out),   W'(sp));
        chk("op_ready", W'(op_ready), W'(!m_pending));
        chk("rd_valid", W'(rd_valid), W'(m_rd_valid));
        chk("rd_data",  rd_data,      m_rd_data);
        chk("full",     W'(full),     W'(sp == 0));
        chk("empty",    W'(empty),    W'(sp == D));
        chk("overflow_err",  W'(overflow_err),  W'(m_ovf && FLAGS_EN));
        chk("underflow_err", W'(underflow_err), W'(m_unf && FLAGS_EN));
    endtask

    // One clock: drive, step model at the edge, compare just after it
    task automatic cyc(input logic rst, input logic [1:0] md, input logic vld,
                       input logic [W-1:0] d0, input logic [W-1:0] d1);
        rst_n    = rst;
        mode     = md;
        op_valid = vld;
        wr_data0 = d0;
        wr_data1 = d1;
        @(posedge clk);
        model_step(rst, md, vld, d0, d1);
        #1;
        compare_all();
    endtask

    initial begin
        m_pending = 1'b0;
        m_rd_data = '0;
        m_ovf     = 1'b0;
        m_unf     = 1'b0;

        // Reset state
        cyc(1'b0, M_HOLD, 1'b0, '0, '0);
        chk("rst sp", W'(sp_out), 32'd16);
        chk("rst ready", W'(op_ready), 32'd1);
        chk("rst empty", W'(empty), 32'd1);

        // Push one then pop returns it
        cyc(1'b1, M_PUSH1, 1'b1, 32'hA5, '0);
        chk("push1 sp", W'(sp_out), 32'd15);
        cyc(1'b1, M_POP, 1'b1, '0, '0);
        chk("pop rd_valid", W'(rd_valid), 32'd1);
        chk("pop rd_data", rd_data, 32'hA5);
        chk("pop empty", W'(empty), 32'd1);
        cyc(1'b1, M_HOLD, 1'b1, '0, '0);
        chk("hold rd_valid", W'(rd_valid), 32'd0);
        chk("hold rd_data", rd_data, 32'hA5);

        // Push two, then pop twice in LIFO order
        cyc(1'b1, M_PUSH2, 1'b1, 32'h11, 32'h22);
        chk("push2 ready", W'(op_ready), 32'd0);
        cyc(1'b1, M_POP, 1'b1, '0, '0);
        chk("push2 sp", W'(sp_out), 32'd14);
        chk("push2 ready back", W'(op_ready), 32'd1);
        cyc(1'b1, M_POP, 1'b1, '0, '0);
        chk("pop2 first", rd_data, 32'h22);
        cyc(1'b1, M_POP, 1'b1, '0, '0);
        chk("pop2 second", rd_data, 32'h11);

        // Underflow, then a legal push
        cyc(1'b1, M_POP, 1'b1, '0, '0);
        chk("unf flag", W'(underflow_err), W'(FLAGS_EN));
        chk("unf sp", W'(sp_out), 32'd16);
        chk("unf rd_valid", W'(rd_valid), 32'd0);
        cyc(1'b1, M_PUSH1, 1'b1, 32'h5A, '0);
        chk("after unf sp", W'(sp_out), 32'd15);

        // Fill to SP 1, push two rejected, push one fills
        for (int i = 0; i < 14; i++) cyc(1'b1, M_PUSH1, 1'b1, W'(i + 100), '0);
        chk("fill sp", W'(sp_out), 32'd1);
        cyc(1'b1, M_PUSH2, 1'b1, 32'hBB, 32'hCC);
        chk("ovf flag", W'(overflow_err), W'(FLAGS_EN));
        chk("ovf sp", W'(sp_out), 32'd1);
        chk("ovf ready", W'(op_ready), 32'd1);
        cyc(1'b1, M_PUSH1, 1'b1, 32'hDD, '0);
        chk("full sp", W'(sp_out), 32'd0);
        chk("full flag", W'(full), 32'd1);
        cyc(1'b1, M_POP, 1'b1, '0, '0);
        chk("pop top", rd_data, 32'hDD);

        // Reset during PUSH2 aborts the second word
        cyc(1'b0, M_HOLD, 1'b0, '0, '0);
        cyc(1'b1, M_PUSH2, 1'b1, 32'h33, 32'h44);
        cyc(1'b0, M_HOLD, 1'b0, '0, '0);
        chk("rst p2 sp", W'(sp_out), 32'd16);
        chk("rst p2 ready", W'(op_ready), 32'd1);
        chk("rst p2 ovf", W'(overflow_err), 32'd0);
        chk("rst p2 unf", W'(underflow_err), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 299) != 0), 2'($urandom_range(0, 3)),
                ($urandom_range(0, 3) != 0), $urandom, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
